// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: turns step commands into Gray-coded A/B phases.
// Optional abort input/aborted output enabled by defining QUADGEN_ABORT_EN.
module quad_encoder_gen #(
    parameter int CNT_WIDTH = 8,
    parameter int DIV_WIDTH = 16,
    parameter int POS_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_dir,
    input  logic [CNT_WIDTH-1:0] cmd_steps,
    input  logic [DIV_WIDTH-1:0] cmd_period,
    output logic                 enc_a,
    output logic                 enc_b,
    output logic                 busy,
    output logic                 done,
`ifdef QUADGEN_ABORT_EN
    input  logic                 abort,
    output logic                 aborted,
`endif
    output logic [POS_WIDTH-1:0] pos
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_next;
    logic                 dir_q, dir_next;
    logic [CNT_WIDTH-1:0] remaining, remaining_next;
    logic [DIV_WIDTH-1:0] period_q, period_next;
    logic [DIV_WIDTH-1:0] divider, divider_next;
    logic [DIV_WIDTH-1:0] period_eff;
    logic                 a_next, b_next, busy_next, done_next;
    logic [POS_WIDTH-1:0] pos_next;
    logic                 last_step;
`ifdef QUADGEN_ABORT_EN
    logic                 aborted_next;
`endif

    assign cmd_ready  = (state == IDLE);
    assign period_eff = (cmd_period == '0) ? DIV_WIDTH'(1) : cmd_period;
    assign last_step  = (divider == '0) && (remaining == CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            remaining <= '0;
            period_q  <= '0;
            divider   <= '0;
            enc_a     <= 1'b0;
            enc_b     <= 1'b0;
            pos       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef QUADGEN_ABORT_EN
            aborted   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            dir_q     <= dir_next;
            remaining <= remaining_next;
            period_q  <= period_next;
            divider   <= divider_next;
            enc_a     <= a_next;
            enc_b     <= b_next;
            pos       <= pos_next;
            busy      <= busy_next;
            done      <= done_next;
`ifdef QUADGEN_ABORT_EN
            aborted   <= aborted_next;
`endif
        end
    end

    always_comb begin
        state_next     = state;
        dir_next       = dir_q;
        remaining_next = remaining;
        period_next    = period_q;
        divider_next   = divider;
        a_next         = enc_a;
        b_next         = enc_b;
        pos_next       = pos;
        busy_next      = busy;
        done_next      = 1'b0;
`ifdef QUADGEN_ABORT_EN
        aborted_next   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    dir_next       = cmd_dir;
                    remaining_next = cmd_steps;
                    period_next    = period_eff;
                    divider_next   = period_eff - DIV_WIDTH'(1);
                    if (cmd_steps == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = RUN;
                        busy_next  = 1'b1;
                    end
                end
            end
            RUN: begin
`ifdef QUADGEN_ABORT_EN
                // A final transition outranks abort so the command still completes.
                if (abort && !last_step) begin
                    state_next   = IDLE;
                    busy_next    = 1'b0;
                    aborted_next = 1'b1;
                end else
`endif
                if (divider == '0) begin
                    // CW: (a,b) <- (~b,a); CCW: (a,b) <- (b,~a)
                    if (dir_q) begin
                        a_next   = ~enc_b;
                        b_next   = enc_a;
                        pos_next = pos + POS_WIDTH'(1);
                    end else begin
                        a_next   = enc_b;
                        b_next   = ~enc_a;
                        pos_next = pos - POS_WIDTH'(1);
                    end
                    remaining_next = remaining - CNT_WIDTH'(1);
                    divider_next   = period_q - DIV_WIDTH'(1);
                    if (last_step) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end else begin
                    divider_next = divider - DIV_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: vector table, random commands vs. a
// position/time reference model, and hand-written reset/abort/wrap sequences.
module tb_quad_encoder_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [7:0]  cmd_steps;
    logic [15:0] cmd_period;
    logic        enc_a, enc_b, busy, done;
    logic [15:0] pos;
    logic        abort = 1'b0;
    logic        aborted;

    int checks = 0;
    int failures = 0;

    // Reference model: net position in quadrature steps; phase is position mod 4.
    int mphase = 0;
    int mpos = 0;
    logic [1:0] lut [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    typedef struct {
        bit          rst;
        bit          d;
        int          st;
        int          pr;
        logic [1:0]  ab;
        logic [15:0] pos_e;
    } vec_t;
    vec_t tbl [6];

    quad_encoder_gen #(.CNT_WIDTH(8), .DIV_WIDTH(16), .POS_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .enc_a(enc_a), .enc_b(enc_b), .busy(busy), .done(done),
`ifdef QUADGEN_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .pos(pos)
    );
`ifndef QUADGEN_ABORT_EN
    assign aborted = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_state(input string name, input bit be, input bit de, input bit abe);
        logic [15:0] p;
        p = mpos[15:0];
        chk(name, {11'd0, enc_a, enc_b, busy, done, cmd_ready, pos},
                  {11'd0, lut[mphase], be, de, !be, p});
`ifdef QUADGEN_ABORT_EN
        chk({name, "_aborted"}, {31'd0, aborted}, {31'd0, abe});
`else
        if (abe) chk({name, "_aborted"}, {31'd0, aborted}, 32'd1);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        mphase = 0;
        mpos = 0;
        @(negedge clk);
        check_state("reset", 0, 0, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_state("idle", 0, 0, 0);
        end
    endtask

    // Issues one command from an idle cycle and checks every cycle through done.
    // junk: cycle index at which a stray command is presented while busy.
    // stop_k: return early at that cycle index (for reset/abort sequences).
    task automatic do_cmd(input bit d, input int st, input int pr, input int junk, input int stop_k);
        int pe, total, n, base_ph, base_pos, delta;
        pe = (pr == 0) ? 1 : pr;
        total = (st == 0) ? 0 : st * pe;
        cmd_dir = d;
        cmd_steps = 8'(st);
        cmd_period = 16'(pr);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_dir = 1'($urandom);
        cmd_steps = 8'($urandom);
        cmd_period = 16'($urandom);
        base_ph = mphase;
        base_pos = mpos;
        for (int k = 0; k <= total; k++) begin
            if (k == junk) begin
                cmd_valid = 1'b1;
                cmd_steps = 8'd9;
                cmd_period = 16'd1;
            end
            if (k == junk + 1) cmd_valid = 1'b0;
            @(negedge clk);
            n = k / pe;
            if (n > st) n = st;
            delta = d ? n : -n;
            mphase = (((base_ph + delta) % 4) + 4) % 4;
            mpos = base_pos + delta;
            check_state("run", (st != 0) && (k < total), k == total, 0);
            if (k == stop_k) return;
            if (k < total) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int st, pr, total, junk;
        bit d;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir = 1'b0;
        cmd_steps = '0;
        cmd_period = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_state("reset_init", 0, 0, 0);

        tbl[0] = '{1'b1, 1'b1, 4, 3, 2'b00, 16'h0004};
        tbl[1] = '{1'b1, 1'b0, 2, 0, 2'b11, 16'hFFFE};
        tbl[2] = '{1'b0, 1'b1, 0, 5, 2'b11, 16'hFFFE};
        tbl[3] = '{1'b0, 1'b1, 1, 1, 2'b01, 16'hFFFF};
        tbl[4] = '{1'b0, 1'b0, 3, 2, 2'b00, 16'hFFFC};
        tbl[5] = '{1'b1, 1'b0, 1, 1, 2'b01, 16'hFFFF};
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].rst) do_reset();
            do_cmd(tbl[i].d, tbl[i].st, tbl[i].pr, -1, -1);
            chk("tbl_end", {14'd0, enc_a, enc_b, pos}, {14'd0, tbl[i].ab, tbl[i].pos_e});
            if (tbl[i].st == 0) idle_cycles(1);
        end

        // Stray command while busy, then a back-to-back accept in the done cycle.
        do_cmd(1'b1, 3, 2, 1, -1);
        do_cmd(1'b1, 2, 4, -1, -1);
        do_cmd(1'b0, 3, 1, 0, -1);
        idle_cycles(2);

        for (int r = 0; r < 25; r++) begin
            d = 1'($urandom_range(0, 1));
            st = $urandom_range(0, 12);
            pr = $urandom_range(0, 5);
            total = (st == 0) ? 0 : st * ((pr == 0) ? 1 : pr);
            junk = (total >= 2) ? $urandom_range(0, total - 2) : -1;
            do_cmd(d, st, pr, junk, -1);
            idle_cycles($urandom_range(0, 2));
        end

        do_reset();
        for (int i = 0; i < 128; i++) do_cmd(1'b1, 255, 1, -1, -1);
        do_cmd(1'b1, 127, 1, -1, -1);
        chk("pos_7fff", {16'd0, pos}, 32'h0000_7FFF);
        do_cmd(1'b1, 1, 1, -1, -1);
        chk("pos_8000", {16'd0, pos}, 32'h0000_8000);

        // Reset asserted right after the 2nd of 5 transitions.
        do_reset();
        do_cmd(1'b1, 5, 2, -1, 4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mphase = 0;
        mpos = 0;
        @(negedge clk);
        check_state("rst_mid", 0, 0, 0);
        idle_cycles(2);

`ifdef QUADGEN_ABORT_EN
        do_reset();
        do_cmd(1'b1, 5, 2, -1, 4);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_pos", {16'd0, pos}, 32'd2);
        check_state("abort", 0, 0, 1);
        idle_cycles(3);
        do_cmd(1'b1, 2, 1, -1, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        mphase = 0;
        mpos = 4;
        @(negedge clk);
        check_state("abort_last", 0, 1, 0);
        abort = 1'b1;
        idle_cycles(1);
        abort = 1'b0;
        idle_cycles(1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
